stack_ctrl: RTL
===============

# stack_ctrl

Sequencer and two-port arbiter for the 16-entry 4-bit LIFO stack. Turns whole-transaction push/pop requests from a data requester (port A) and a program-counter requester (port B, call/return) into the cycle-exact push/pop/we/re/mux-select strobes the stack needs. Also issues the stack's synchronous pointer reset after system reset, blocks overflow and underflow, and returns popped data in a register. Sits between the core control unit / PC logic and the stack instance.

## Interface
- No parameters; widths fixed: data 4 bits, stack capacity 16 entries.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A request, held until a_ack or a_err
- a_op  in  1  port A op: 1 = push, 0 = pop; stable while a_req high
- b_req  in  1  port B (PC) request: push = call, pop = return
- b_op  in  1  port B op, same encoding as a_op
- a_ack / b_ack  out  1  one-cycle completion pulse
- a_err / b_err  out  1  one-cycle rejection pulse: push while full, or pop while empty
- rdata  out  4  popped value; valid in the ack cycle of a pop and held until the next pop completes
- busy  out  1  high in every state except IDLE
- stk_reset  out  1  to stack pointer rst; synchronous, active-high
- stk_push, stk_pop, stk_we, stk_re  out  1  stack strobes
- stk_mux_sel  out  1  1 = port A data, 0 = port B PC
- stk_dout  in  4  stack read data (combinational from the stack)
- stk_full, stk_empty  in  1  stack status

## Operation
- FSM states: INIT, IDLE, PUSH, POP_DEC, POP_RD, ACK, ERR. All stk_* outputs are decoded from the registered state and the registered grant, so they are glitch-free.
- INIT: stk_reset=1. Entered asynchronously on rst_n low. Moves to IDLE on the first clock edge after rst_n is high.
- IDLE: if any req is high, arbitrate and latch the grant (A/B) and op.
  - Grant push with stk_full=1 -> ERR.
  - Grant pop with stk_empty=1 -> ERR.
  - Otherwise: push -> PUSH, pop -> POP_DEC.
- PUSH: stk_push=1, stk_we=1, stk_mux_sel = (grant==A). The write lands at the current pointer; the pointer increments on the same edge. Next state ACK.
- POP_DEC: stk_pop=1. The pointer decrements to the top entry. Next state POP_RD.
- POP_RD: stk_re=1; rdata <= stk_dout at the end of the cycle. Next state ACK.
- ACK: the granted port's ack=1 for one cycle. Next state IDLE.
- ERR: the granted port's err=1 for one cycle. No stack strobe is asserted. Next state IDLE.
- stk_we is never asserted while stk_full=1. stk_pop is never asserted while stk_empty=1.
- Requests are sampled only in IDLE. A req dropped mid-transaction does not abort it; the ack or err is still issued.
- A requester must drop req in the cycle after its ack/err, or it is treated as a new request.

## Timing
- Reset values: state=INIT, stk_reset=1, all other strobes 0, a_ack/b_ack/a_err/b_err=0, rdata=4'h0, busy=1, last_grant=B.
- Push: req sampled in IDLE at edge N; PUSH during cycle N+1; ack during cycle N+2. Total latency 2 cycles.
- Pop: POP_DEC in cycle N+1; POP_RD in N+2; ack and rdata valid in N+3. Total latency 3 cycles.
- Error: err pulse in cycle N+1.
- A new grant is possible in the cycle after ACK/ERR. Back-to-back pushes therefore take 3 cycles each.
- An async reset mid-transaction aborts it: no ack is issued, and INIT reclears the stack pointer.

## Configuration
- STACK_CTRL_RR_EN defined: round-robin arbitration. On simultaneous requests in IDLE, grant the port not in last_grant. last_grant updates on every grant, including error grants.
- STACK_CTRL_RR_EN undefined: fixed priority. Port B always wins a conflict. last_grant is not implemented.
- A lone request is granted immediately in both builds.

## Test plan
- Reset release: stk_reset=1 through reset and for one cycle after; then busy=0; all acks/errs 0; rdata=0.
- A pushes 4'h5, 4'h9, then pops twice: a_ack after 2 / 2 / 3 / 3 cycles; rdata=4'h9, then 4'h5; stk_empty=1 at the end.
- B pushes 16 values (PC 0..F) with stk_mux_sel=0 on each; 17th push -> b_err, no stk_we; then a pop returns 4'hF.
- Pop on an empty stack from A -> a_err in N+1; stk_pop is never asserted; the pointer stays 0.
- a_req and b_req rise together, three times: with STACK_CTRL_RR_EN, grants go A, B, A; without it, grants go B, B, B.
- rst_n asserted during POP_RD: all outputs return to reset values immediately; no ack; the next push lands at address 0.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// Requester-side bus of stack_ctrl: port A (data) and port B (PC call/return)
// request/response handshake plus popped data and busy status.
interface stack_ctrl_if;
  logic       a_req;
  logic       a_op;
  logic       b_req;
  logic       b_op;
  logic       a_ack;
  logic       b_ack;
  logic       a_err;
  logic       b_err;
  logic [3:0] rdata;
  logic       busy;

  modport master (
    output a_req, a_op, b_req, b_op,
    input  a_ack, b_ack, a_err, b_err, rdata, busy
  );

  modport slave (
    input  a_req, a_op, b_req, b_op,
    output a_ack, b_ack, a_err, b_err, rdata, busy
  );
endinterface

// File: rtl/stack_ctrl.sv
// Sequencer/arbiter for a 16x4 LIFO: turns A/B push/pop transactions into stack strobes.
// Optional macro STACK_CTRL_RR_EN selects round-robin arbitration instead of fixed B priority.
module stack_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  stack_ctrl_if.slave  bus,
  output logic         stk_reset,
  output logic         stk_push,
  output logic         stk_pop,
  output logic         stk_we,
  output logic         stk_re,
  output logic         stk_mux_sel,
  input  logic [3:0]   stk_dout,
  input  logic         stk_full,
  input  logic         stk_empty
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    PUSH    = 3'd2,
    POP_DEC = 3'd3,
    POP_RD  = 3'd4,
    ACK     = 3'd5,
    ERR     = 3'd6
  } state_t;

  state_t state_r;
  logic   grant_a_r;
  logic   any_req_s;
  logic   grant_a_s;
  logic   op_push_s;
  logic   reject_s;

`ifdef STACK_CTRL_RR_EN
  logic   last_grant_a_r;
`endif

  // Arbitration and overflow/underflow screening of the request seen in IDLE
  always_comb begin
    any_req_s = bus.a_req | bus.b_req;
    grant_a_s = 1'b0;
    if (bus.a_req && bus.b_req) begin
`ifdef STACK_CTRL_RR_EN
      grant_a_s = ~last_grant_a_r;
`else
      grant_a_s = 1'b0;
`endif
    end else if (bus.a_req) begin
      grant_a_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
    end
    op_push_s = grant_a_s ? bus.a_op : bus.b_op;
    reject_s  = op_push_s ? stk_full : stk_empty;
  end

`ifdef STACK_CTRL_RR_EN
  // Remember the last granted port, error grants included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_a_r <= 1'b0;
    end else if (state_r == IDLE && any_req_s) begin
      last_grant_a_r <= grant_a_s;
    end else begin
      last_grant_a_r <= last_grant_a_r;
    end
  end
`endif

  // Transaction FSM; every output is registered against the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INIT;
      grant_a_r   <= 1'b0;
      stk_reset   <= 1'b1;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_we      <= 1'b0;
      stk_re      <= 1'b0;
      stk_mux_sel <= 1'b0;
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_err   <= 1'b0;
      bus.b_err   <= 1'b0;
      bus.rdata   <= 4'h0;
      bus.busy    <= 1'b1;
    end else begin
      stk_reset   <= 1'b0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_we      <= 1'b0;
      stk_re      <= 1'b0;
      stk_mux_sel <= 1'b0;
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_err   <= 1'b0;
      bus.b_err   <= 1'b0;
      bus.busy    <= 1'b1;
      case (state_r)
        INIT: begin
          state_r  <= IDLE;
          bus.busy <= 1'b0;
        end
        IDLE: begin
          if (any_req_s) begin
            grant_a_r <= grant_a_s;
            if (reject_s) begin
              state_r   <= ERR;
              bus.a_err <= grant_a_s;
              bus.b_err <= ~grant_a_s;
            end else if (op_push_s) begin
              state_r     <= PUSH;
              stk_push    <= 1'b1;
              stk_we      <= 1'b1;
              stk_mux_sel <= grant_a_s;
            end else begin
              state_r <= POP_DEC;
              stk_pop <= 1'b1;
            end
          end else begin
            state_r  <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        PUSH: begin
          state_r   <= ACK;
          bus.a_ack <= grant_a_r;
          bus.b_ack <= ~grant_a_r;
        end
        POP_DEC: begin
          state_r <= POP_RD;
          stk_re  <= 1'b1;
        end
        POP_RD: begin
          // Pointer already sits on the top entry, so stk_dout is the popped value
          state_r   <= ACK;
          bus.rdata <= stk_dout;
          bus.a_ack <= grant_a_r;
          bus.b_ack <= ~grant_a_r;
        end
        ACK, ERR: begin
          state_r  <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state_r   <= INIT;
          stk_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
